// File: rtl/lif_tdm_scheduler_if.sv
// Bus bundle for the LIF TDM scheduler: sweep control, spike inputs,
// threshold config, event FIFO handshake and status flags.
interface lif_tdm_scheduler_if #(
   parameter int N_NEURONS = 4,
   parameter int V_W       = 8
);
   localparam int ID_W = $clog2(N_NEURONS);

   logic                 tick;
   logic [N_NEURONS-1:0] spike_in;
   logic                 cfg_we;
   logic [V_W-1:0]       cfg_thresh;
   logic                 ev_valid;
   logic [ID_W-1:0]      ev_id;
   logic                 ev_ready;
   logic                 busy;
   logic                 overrun;
   logic                 ev_drop;

   modport master (
      output tick, spike_in, cfg_we, cfg_thresh, ev_ready,
      input  ev_valid, ev_id, busy, overrun, ev_drop
   );

   modport slave (
      input  tick, spike_in, cfg_we, cfg_thresh, ev_ready,
      output ev_valid, ev_id, busy, overrun, ev_drop
   );
endinterface

// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one shared update
// datapath sweeps all neurons per tick and queues fire events in a FIFO.
module lif_tdm_scheduler #(
   parameter int N_NEURONS      = 4,
   parameter int V_W            = 8,
   parameter int W_IN           = 64,
   parameter int LEAK_SHIFT     = 3,
   parameter int THRESH_DEFAULT = 200,
   parameter int FIFO_DEPTH     = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   lif_tdm_scheduler_if.slave   bus
);
   localparam int ID_W = $clog2(N_NEURONS);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam logic [V_W:0]      W_IN_EXT  = (V_W+1)'(W_IN);
   localparam logic [AW:0]       DEPTH_EXT = (AW+1)'(FIFO_DEPTH);
   localparam logic [ID_W-1:0]   LAST_IDX  = ID_W'(N_NEURONS - 1);
   localparam logic [V_W-1:0]    TH_RST    = V_W'(THRESH_DEFAULT);

   typedef enum logic {S_IDLE, S_UPDATE} state_t;

   state_t               r_state, w_state_next;
   logic [ID_W-1:0]      r_idx, w_idx_next;
   logic                 w_start;
   logic [V_W-1:0]       r_v [N_NEURONS];
   logic [N_NEURONS-1:0] r_pend;
   logic [N_NEURONS-1:0] w_clr;
   logic [V_W-1:0]       r_thresh_active, r_thresh_shadow;
   logic                 r_overrun, r_ev_drop;
   logic [ID_W-1:0]      r_fifo [FIFO_DEPTH];
   logic [AW:0]          r_wr_ptr, r_rd_ptr;

   logic                 w_updating;
   logic [V_W-1:0]       w_v_cur, w_v_leak, w_sum_sat;
   logic [V_W:0]         w_sum;
   logic                 w_fire;
   logic                 w_ev_valid, w_full, w_pop, w_push, w_drop;

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_start      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.tick) begin
               w_state_next = S_UPDATE;
               w_idx_next   = '0;
               w_start      = 1'b1;
            end
         end
         S_UPDATE: begin
            w_idx_next = r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Shared datapath; the leak term is a fraction of V so it never underflows.
   assign w_updating = (r_state == S_UPDATE);
   assign w_v_cur    = r_v[r_idx];
   assign w_v_leak   = w_v_cur - (w_v_cur >> LEAK_SHIFT);
   assign w_sum      = {1'b0, w_v_leak} + (r_pend[r_idx] ? W_IN_EXT : '0);
   assign w_sum_sat  = w_sum[V_W] ? '1 : w_sum[V_W-1:0];
   assign w_fire     = w_updating && (w_sum_sat >= r_thresh_active);

   generate
      for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_clr
         assign w_clr[gi] = w_updating && (r_idx == ID_W'(gi));
      end
   endgenerate

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   assign w_ev_valid = (r_wr_ptr != r_rd_ptr);
   assign w_full     = ((r_wr_ptr - r_rd_ptr) == DEPTH_EXT);
   assign w_pop      = w_ev_valid && bus.ev_ready;
   assign w_push     = w_fire && (!w_full || w_pop);
   assign w_drop     = w_fire && w_full && !w_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_idx           <= '0;
         r_pend          <= '0;
         r_thresh_active <= TH_RST;
         r_thresh_shadow <= TH_RST;
         r_overrun       <= 1'b0;
         r_ev_drop       <= 1'b0;
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         for (int i = 0; i < N_NEURONS; i++) begin
            r_v[i] <= '0;
         end
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
         r_pend  <= (r_pend & ~w_clr) | bus.spike_in;
         if (bus.cfg_we) begin
            r_thresh_shadow <= bus.cfg_thresh;
         end
         if (w_start) begin
            r_thresh_active <= r_thresh_shadow;
         end
         if (w_updating && bus.tick) begin
            r_overrun <= 1'b1;
         end
         if (w_drop) begin
            r_ev_drop <= 1'b1;
         end
         if (w_updating) begin
            r_v[r_idx] <= w_fire ? '0 : w_sum_sat;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr[AW-1:0]] <= r_idx;
      end
   end

   assign bus.ev_valid = w_ev_valid;
   assign bus.ev_id    = r_fifo[r_rd_ptr[AW-1:0]];
   assign bus.busy     = w_updating;
   assign bus.overrun  = r_overrun;
   assign bus.ev_drop  = r_ev_drop;
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Scoreboard bench for lif_tdm_scheduler: directed sweeps with hand-computed
// membrane values; expected event ids are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_lif_tdm_scheduler;
   localparam int N   = 4;
   localparam int V_W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   exp_q[$];

   lif_tdm_scheduler_if #(.N_NEURONS(N), .V_W(V_W)) bus ();

   lif_tdm_scheduler #(
      .N_NEURONS(N), .V_W(V_W), .W_IN(64), .LEAK_SHIFT(3),
      .THRESH_DEFAULT(200), .FIFO_DEPTH(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // Monitor: every accepted event is compared against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && bus.ev_valid && bus.ev_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ev_unexpected: got id %0d expected no event", bus.ev_id);
         end else begin
            check("ev_id_pop", 32'(bus.ev_id), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sweep();
      bus.tick = 1'b1;
      step(1);
      bus.tick = 1'b0;
      step(N);
   endtask

   task automatic spike(input logic [N-1:0] m);
      bus.spike_in = m;
      step(1);
      bus.spike_in = '0;
   endtask

   task automatic push_all();
      for (int i = 0; i < N; i++) exp_q.push_back(i);
   endtask

   initial begin
      int v0_exp[4];
      int v1_exp[3];
      int v_cfg[4];
      v0_exp = '{64, 120, 169, 0};
      v1_exp = '{105, 92, 81};
      v_cfg  = '{64, 113, 64, 64};

      bus.tick = 1'b0; bus.spike_in = '0; bus.cfg_we = 1'b0;
      bus.cfg_thresh = '0; bus.ev_ready = 1'b1;
      step(3);
      check("rst_busy", bus.busy, 0);
      check("rst_ev_valid", bus.ev_valid, 0);
      check("rst_overrun", bus.overrun, 0);
      check("rst_ev_drop", bus.ev_drop, 0);
      rst_n = 1'b1;
      step(1);

      // Integrate-and-fire on neuron 0: 64, 120, 169, then 212 fires.
      for (int s = 0; s < 4; s++) begin
         spike(4'b0001);
         if (s == 3) begin
            exp_q.push_back(0);
            bus.tick = 1'b1;
            step(1);
            bus.tick = 1'b0;
            step(1);
            check("fire_ev_valid", bus.ev_valid, 1);
            check("fire_ev_id", bus.ev_id, 0);
            step(N - 1);
         end else begin
            sweep();
         end
         check($sformatf("v0_sweep%0d", s), dut.r_v[0], v0_exp[s]);
      end

      // Leak only on neuron 1.
      spike(4'b0010); sweep();
      spike(4'b0010); sweep();
      check("v1_charged", dut.r_v[1], 120);
      for (int s = 0; s < 3; s++) begin
         sweep();
         check($sformatf("v1_leak%0d", s), dut.r_v[1], v1_exp[s]);
      end
      check("leak_no_event", bus.ev_valid, 0);

      // Continuous tick: accepted every N+1 cycles, overrun sets.
      check("overrun_before", bus.overrun, 0);
      bus.tick = 1'b1;
      for (int j = 0; j < 15; j++) begin
         step(1);
         check($sformatf("busy_cycle%0d", j), bus.busy, ((j % 5) != 4));
      end
      bus.tick = 1'b0;
      check("overrun_after", bus.overrun, 1);
      check("v1_after_three", dut.r_v[1], 56);

      // Threshold written mid-sweep applies from the next sweep.
      spike(4'b1111);
      bus.tick = 1'b1;
      step(1);
      bus.tick = 1'b0;
      bus.cfg_we = 1'b1;
      bus.cfg_thresh = 8'd0;
      step(1);
      bus.cfg_we = 1'b0;
      step(N - 1);
      for (int i = 0; i < N; i++) check($sformatf("cfg_v%0d", i), dut.r_v[i], v_cfg[i]);
      check("cfg_no_fire", bus.ev_valid, 0);
      push_all();
      sweep();
      step(2);
      for (int i = 0; i < N; i++) check($sformatf("cfg_fired_v%0d", i), dut.r_v[i], 0);
      check("cfg_q_drained", exp_q.size(), 0);

      // Full FIFO with simultaneous push and pop loses nothing.
      bus.ev_ready = 1'b0;
      push_all();
      sweep();
      check("full_ev_valid", bus.ev_valid, 1);
      check("full_ev_id", bus.ev_id, 0);
      push_all();
      bus.tick = 1'b1;
      step(1);
      bus.tick = 1'b0;
      bus.ev_ready = 1'b1;
      step(N);
      step(5);
      check("pushpop_empty", bus.ev_valid, 0);
      check("pushpop_q", exp_q.size(), 0);
      check("pushpop_no_drop", bus.ev_drop, 0);

      // Overflow: second sweep's events are dropped.
      bus.ev_ready = 1'b0;
      push_all();
      sweep();
      check("drop_before", bus.ev_drop, 0);
      sweep();
      check("drop_after", bus.ev_drop, 1);
      check("drop_head_valid", bus.ev_valid, 1);
      check("drop_head_id", bus.ev_id, 0);
      step(3);
      check("head_stable_id", bus.ev_id, 0);
      bus.ev_ready = 1'b1;
      step(4);
      bus.ev_ready = 1'b0;
      check("drain_empty", bus.ev_valid, 0);
      check("drain_q", exp_q.size(), 0);
      bus.ev_ready = 1'b1;

      // Spike on the exact update cycle of neuron 2 survives the clear.
      bus.cfg_we = 1'b1;
      bus.cfg_thresh = 8'd200;
      step(1);
      bus.cfg_we = 1'b0;
      spike(4'b0100);
      bus.tick = 1'b1;
      step(1);
      bus.tick = 1'b0;
      step(2);
      bus.spike_in = 4'b0100;
      step(1);
      bus.spike_in = '0;
      step(1);
      check("clrset_v2", dut.r_v[2], 64);
      check("clrset_pend2", dut.r_pend[2], 1);
      sweep();
      check("clrset_v2_next", dut.r_v[2], 120);
      check("clrset_pend2_cleared", dut.r_pend[2], 0);

      // Reset mid-sweep restores flags, potentials and threshold.
      bus.cfg_we = 1'b1;
      bus.cfg_thresh = 8'd0;
      step(1);
      bus.cfg_we = 1'b0;
      bus.tick = 1'b1;
      step(2);
      bus.tick = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", bus.busy, 0);
      check("midrst_ev_valid", bus.ev_valid, 0);
      check("midrst_overrun", bus.overrun, 0);
      check("midrst_ev_drop", bus.ev_drop, 0);
      for (int i = 0; i < N; i++) check($sformatf("midrst_v%0d", i), dut.r_v[i], 0);
      step(1);
      rst_n = 1'b1;
      step(1);
      spike(4'b0001);
      sweep();
      step(1);
      check("postrst_v0", dut.r_v[0], 64);
      for (int i = 1; i < N; i++) check($sformatf("postrst_v%0d", i), dut.r_v[i], 0);
      check("postrst_no_event", bus.ev_valid, 0);
      check("final_q_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lif_tdm_scheduler.md
# lif_tdm_scheduler

Time-multiplexed scheduler that shares one leaky integrate-and-fire update datapath among N_NEURONS virtual neurons. It sits between the TT top-level pins and the neuron logic: it latches input spikes per neuron, sweeps all membrane potentials once per `tick`, and queues output spike events in a small FIFO with a valid/ready handshake. The threshold is programmable at run time through a single-register config port.

## Interface
- N_NEURONS, 4: virtual neurons; a power of two, at least 2.
- V_W, 8: membrane potential width (unsigned).
- W_IN, 64: weight added when a neuron's pending input bit is set.
- LEAK_SHIFT, 3: leak = V >> LEAK_SHIFT.
- THRESH_DEFAULT, 200: threshold reset value.
- FIFO_DEPTH, 4: event FIFO entries; a power of two.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  starts one update sweep.
- spike_in  in  N_NEURONS  per-neuron input spike pulses.
- cfg_we  in  1  write strobe for the threshold.
- cfg_thresh  in  V_W  new threshold value.
- ev_valid  out  1  FIFO non-empty.
- ev_id  out  log2(N_NEURONS)  index of the neuron at the FIFO head.
- ev_ready  in  1  consumer accepts the head event.
- busy  out  1  sweep in progress.
- overrun  out  1  sticky: a tick arrived while busy.
- ev_drop  out  1  sticky: an event was lost because the FIFO was full.

## Operation
- Reset sets all V[i], pending bits, FIFO pointers and flags to 0, the FSM to IDLE, and thresh_active and thresh_shadow to THRESH_DEFAULT.
- Pending bits:
  - A spike_in[i] high sets pend[i].
  - pend[i] clears when neuron i is updated.
  - If spike_in[i] is high in the same cycle as the clear, pend[i] stays set and counts in the next sweep.
- Config:
  - cfg_we writes thresh_shadow.
  - thresh_active loads from thresh_shadow on sweep start only.
  - A write during a sweep therefore takes effect on the next sweep.
- FSM has two states, IDLE and UPDATE.
  - IDLE: tick=1 moves to UPDATE with idx=0 and thresh_active loaded.
  - UPDATE: one neuron is updated per cycle; idx increments; after idx=N_NEURONS-1 the FSM returns to IDLE.
  - A tick seen in UPDATE is ignored and sets overrun.
- Per-neuron update (combinational, single shared datapath):
  - v_leak = V - (V >> LEAK_SHIFT); this cannot underflow.
  - sum = v_leak + (pend ? W_IN : 0), computed at V_W+1 bits and saturated to 2^V_W-1.
  - If sum >= thresh_active the neuron fires: V is written to 0 and idx is pushed to the FIFO.
  - Otherwise V is written with sum.
  - thresh_active = 0 makes every updated neuron fire.
- FIFO:
  - A pop occurs on ev_valid & ev_ready.
  - If the FIFO is full and a push and a pop occur in the same cycle, both succeed and nothing is dropped.
  - A push into a full FIFO without a pop is discarded and sets ev_drop.
- overrun and ev_drop clear only on reset.
- Reset asserted mid-sweep aborts the sweep immediately and restores all reset values.

## Timing
- Sweep sequence:
  - tick is sampled high at edge k while in IDLE.
  - Neuron i is written at edge k+1+i.
  - The FSM returns to IDLE at edge k+N_NEURONS.
- busy is registered; it is high from after edge k until after edge k+N_NEURONS.
- A new tick is accepted at edge k+N_NEURONS+1 or later.
- A tick at any edge k+1 … k+N_NEURONS sets overrun.
- Sweep period is N_NEURONS cycles, plus 1 idle cycle before re-arm.
- Event latency: a fire at edge e gives ev_valid=1 after edge e if the FIFO was empty.
- ev_id is stable while ev_valid is high and ev_ready is low.
- All outputs are registered or taken directly from register state; there are no combinational paths from inputs to outputs.

## Test plan
- Reset values: assert rst_n=0 mid-sweep → busy=0, ev_valid=0, overrun=0, ev_drop=0, and every V=0 on the next sweep.
- Integrate-and-fire, defaults:
  - Stimulus: spike_in[0] pulsed before each of four sweeps.
  - Required V0 sequence: 64, 120, 169, then sum 212 ≥ 200 fires.
  - After the fire: V0=0, ev_id=0 with ev_valid=1 one cycle after edge k+1.
- Leak only: V1=120 with no input → 105, then 92, then 81 across three sweeps; no event.
- Overrun and config shadowing:
  - Stimulus: tick held high continuously.
  - Required: ticks are accepted every 5 cycles, and overrun sets.
  - Stimulus: cfg_thresh=0 written mid-sweep.
  - Required: no fires in the current sweep (all V below 200); all 4 neurons fire in the next sweep.
- FIFO full:
  - Stimulus: thresh=0, ev_ready=0, two sweeps.
  - Required: 4 events queued with ids 0,1,2,3; ev_drop=1.
  - Stimulus: ev_ready=1 for 4 cycles.
  - Required: ids drain in order 0,1,2,3, then ev_valid=0.
- Same-cycle clear and set: spike_in[2] high on the exact cycle neuron 2 is updated → pend[2] is still set and adds W_IN in the following sweep.
